// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding unit.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_LU    = 2'd1,
        ST_MWAIT = 2'd2
    } hz_state_e;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_EX  = 2'd1;
    localparam logic [1:0] FWD_MEM = 2'd2;
    localparam logic [1:0] FWD_WB  = 2'd3;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when an ID source that is actually read names the given destination.
    function automatic logic src_hit(input logic use_src, input logic [4:0] src,
                                     input logic [4:0] dest);
        return use_src && (src == dest);
    endfunction

endpackage

// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side signal bundle of the hazard/forwarding unit.
interface hazard_forward_unit_if;
    logic [4:0]  id_ra, id_rb, id_rd;
    logic        id_use_a, id_use_b, id_use_d;
    logic [4:0]  ex_dest;
    logic        ex_rf_le, ex_load;
    logic [4:0]  mem_dest;
    logic        mem_rf_le;
    logic [4:0]  wb_dest;
    logic        wb_rf_le;
    logic        ex_br_taken, ex_br_nullify;
    logic        mem_wait;
    logic        pc_le, npc_le, if_id_le;
    logic        id_ex_le, ex_mem_le, mem_wb_le;
    logic        cmux_sel, if_id_clr;
    logic [1:0]  fwd_a, fwd_b, fwd_d;
    logic [15:0] stall_cnt;

    modport slave (
        input  id_ra, id_rb, id_rd, id_use_a, id_use_b, id_use_d,
               ex_dest, ex_rf_le, ex_load, mem_dest, mem_rf_le,
               wb_dest, wb_rf_le, ex_br_taken, ex_br_nullify, mem_wait,
        output pc_le, npc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le,
               cmux_sel, if_id_clr, fwd_a, fwd_b, fwd_d, stall_cnt
    );

    modport master (
        output id_ra, id_rb, id_rd, id_use_a, id_use_b, id_use_d,
               ex_dest, ex_rf_le, ex_load, mem_dest, mem_rf_le,
               wb_dest, wb_rf_le, ex_br_taken, ex_br_nullify, mem_wait,
        input  pc_le, npc_le, if_id_le, id_ex_le, ex_mem_le, mem_wb_le,
               cmux_sel, if_id_clr, fwd_a, fwd_b, fwd_d, stall_cnt
    );
endinterface

// File: rtl/fwd_select.sv
// Operand source select for one ID operand: nearest in-flight producer wins.
module fwd_select
    import hazard_pkg::*;
(
    input  logic [4:0] src_i,
    input  logic [4:0] ex_dest_i,
    input  logic       ex_rf_le_i,
    input  logic       ex_load_i,
    input  logic [4:0] mem_dest_i,
    input  logic       mem_rf_le_i,
    input  logic [4:0] wb_dest_i,
    input  logic       wb_rf_le_i,
    output logic [1:0] sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (src_i != REG_ZERO) begin
            // A load in EX has no data yet; the load-use stall covers that case.
            if (ex_rf_le_i && !ex_load_i && (ex_dest_i == src_i))
                sel_o = FWD_EX;
            else if (mem_rf_le_i && (mem_dest_i == src_i))
                sel_o = FWD_MEM;
            else if (wb_rf_le_i && (wb_dest_i == src_i))
                sel_o = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard control: memory-wait freeze, branch flush, load-use stall,
// operand forwarding selects and a saturating stall-cycle counter.
module hazard_forward_unit
    import hazard_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    hazard_forward_unit_if.slave  hz
);

    hz_state_e   state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        front_le, back_le, cmux, clr;
    logic        lu_hazard;
    logic [1:0]  sel_a, sel_b, sel_d;

    assign lu_hazard = hz.ex_load && hz.ex_rf_le && (hz.ex_dest != REG_ZERO) &&
                       (src_hit(hz.id_use_a, hz.id_ra, hz.ex_dest) ||
                        src_hit(hz.id_use_b, hz.id_rb, hz.ex_dest) ||
                        src_hit(hz.id_use_d, hz.id_rd, hz.ex_dest));

    always_comb begin
        front_le = 1'b1;
        back_le  = 1'b1;
        cmux     = 1'b0;
        clr      = 1'b0;
        state_d  = ST_RUN;
        if (!reset) begin
            front_le = 1'b0;
            back_le  = 1'b0;
            cmux     = 1'b1;
            clr      = 1'b1;
        end else if (hz.mem_wait) begin
            front_le = 1'b0;
            back_le  = 1'b0;
            state_d  = ST_MWAIT;
        end else if (hz.ex_br_taken) begin
            clr  = 1'b1;
            cmux = hz.ex_br_nullify;
        end else if (lu_hazard && (state_q != ST_LU)) begin
            // MWAIT exit re-evaluates the held inputs exactly like RUN.
            front_le = 1'b0;
            cmux     = 1'b1;
            state_d  = ST_LU;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (!front_le && (cnt_q != '1))
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    fwd_select u_fwd_a (
        .src_i       (hz.id_ra),
        .ex_dest_i   (hz.ex_dest),
        .ex_rf_le_i  (hz.ex_rf_le),
        .ex_load_i   (hz.ex_load),
        .mem_dest_i  (hz.mem_dest),
        .mem_rf_le_i (hz.mem_rf_le),
        .wb_dest_i   (hz.wb_dest),
        .wb_rf_le_i  (hz.wb_rf_le),
        .sel_o       (sel_a)
    );

    fwd_select u_fwd_b (
        .src_i       (hz.id_rb),
        .ex_dest_i   (hz.ex_dest),
        .ex_rf_le_i  (hz.ex_rf_le),
        .ex_load_i   (hz.ex_load),
        .mem_dest_i  (hz.mem_dest),
        .mem_rf_le_i (hz.mem_rf_le),
        .wb_dest_i   (hz.wb_dest),
        .wb_rf_le_i  (hz.wb_rf_le),
        .sel_o       (sel_b)
    );

    fwd_select u_fwd_d (
        .src_i       (hz.id_rd),
        .ex_dest_i   (hz.ex_dest),
        .ex_rf_le_i  (hz.ex_rf_le),
        .ex_load_i   (hz.ex_load),
        .mem_dest_i  (hz.mem_dest),
        .mem_rf_le_i (hz.mem_rf_le),
        .wb_dest_i   (hz.wb_dest),
        .wb_rf_le_i  (hz.wb_rf_le),
        .sel_o       (sel_d)
    );

    assign hz.pc_le     = front_le;
    assign hz.npc_le    = front_le;
    assign hz.if_id_le  = front_le;
    assign hz.id_ex_le  = back_le;
    assign hz.ex_mem_le = back_le;
    assign hz.mem_wb_le = back_le;
    assign hz.cmux_sel  = cmux;
    assign hz.if_id_clr = clr;
    assign hz.fwd_a     = reset ? sel_a : FWD_RF;
    assign hz.fwd_b     = reset ? sel_b : FWD_RF;
    assign hz.fwd_d     = reset ? sel_d : FWD_RF;
    assign hz.stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Scoreboard bench for hazard_forward_unit: directed vectors push expected
// outputs; a negedge monitor pops and compares.
module tb_hazard_forward_unit;

    logic clk;
    logic reset;
    hazard_forward_unit_if hz ();

    hazard_forward_unit dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [5:0]  le;
        logic        cm;
        logic        cl;
        logic [1:0]  fa, fb, fd;
        logic [15:0] cnt;
    } exp_t;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    localparam logic [5:0] ALL  = 6'b111111;
    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] BUBL = 6'b000111;

    task automatic expect_now(input string nm, input logic [5:0] le, input logic cm,
                              input logic cl, input logic [1:0] fa, input logic [1:0] fb,
                              input logic [1:0] fd, input logic [15:0] cnt);
        exp_t e;
        e.name = nm; e.le = le; e.cm = cm; e.cl = cl;
        e.fa = fa; e.fb = fb; e.fd = fd; e.cnt = cnt;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        hz.id_ra = '0; hz.id_rb = '0; hz.id_rd = '0;
        hz.id_use_a = 1'b0; hz.id_use_b = 1'b0; hz.id_use_d = 1'b0;
        hz.ex_dest = '0; hz.ex_rf_le = 1'b0; hz.ex_load = 1'b0;
        hz.mem_dest = '0; hz.mem_rf_le = 1'b0;
        hz.wb_dest = '0; hz.wb_rf_le = 1'b0;
        hz.ex_br_taken = 1'b0; hz.ex_br_nullify = 1'b0;
        hz.mem_wait = 1'b0;
    endtask

    task automatic set_load_use();
        hz.ex_load = 1'b1; hz.ex_rf_le = 1'b1; hz.ex_dest = 5'd5;
        hz.id_ra = 5'd5; hz.id_use_a = 1'b1;
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            logic [5:0] le;
            e = q.pop_front();
            le = {hz.pc_le, hz.npc_le, hz.if_id_le, hz.id_ex_le, hz.ex_mem_le, hz.mem_wb_le};
            checks++;
            if (le !== e.le || hz.cmux_sel !== e.cm || hz.if_id_clr !== e.cl ||
                hz.fwd_a !== e.fa || hz.fwd_b !== e.fb || hz.fwd_d !== e.fd ||
                hz.stall_cnt !== e.cnt) begin
                errors++;
                $display("FAIL %s: got le=%b cm=%b cl=%b fa=%0d fb=%0d fd=%0d cnt=%h, want le=%b cm=%b cl=%b fa=%0d fb=%0d fd=%0d cnt=%h",
                         e.name, le, hz.cmux_sel, hz.if_id_clr, hz.fwd_a, hz.fwd_b, hz.fwd_d,
                         hz.stall_cnt, e.le, e.cm, e.cl, e.fa, e.fb, e.fd, e.cnt);
            end
        end
    end

    initial begin
        reset = 1'b0;
        clear_in();
        tick();
        tick();
        // Forwarding inputs live during reset, outputs must still be forced to RF.
        hz.ex_dest = 5'd3; hz.ex_rf_le = 1'b1; hz.id_rb = 5'd3; hz.id_use_b = 1'b1;
        expect_now("reset_out", NONE, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 16'h0000);
        tick();

        reset = 1'b1;
        clear_in();
        expect_now("first_run", ALL, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0000);
        tick();

        set_load_use();
        expect_now("lu_bubble", BUBL, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0000);
        tick();
        expect_now("lu_state", ALL, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0001);
        tick();
        clear_in();
        expect_now("lu_back_run", ALL, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0001);
        tick();

        hz.ex_dest = 5'd3; hz.ex_rf_le = 1'b1;
        hz.mem_dest = 5'd3; hz.mem_rf_le = 1'b1;
        hz.wb_dest = 5'd3; hz.wb_rf_le = 1'b1;
        hz.id_rb = 5'd3; hz.id_use_b = 1'b1;
        expect_now("fwd_ex", ALL, 1'b0, 1'b0, 2'd0, 2'd1, 2'd0, 16'h0001);
        tick();
        hz.ex_rf_le = 1'b0;
        expect_now("fwd_mem", ALL, 1'b0, 1'b0, 2'd0, 2'd2, 2'd0, 16'h0001);
        tick();
        hz.mem_rf_le = 1'b0;
        expect_now("fwd_wb", ALL, 1'b0, 1'b0, 2'd0, 2'd3, 2'd0, 16'h0001);
        tick();
        hz.wb_rf_le = 1'b0;
        expect_now("fwd_rf", ALL, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0001);
        tick();
        // Load in EX is never an EX forward; unused source means no stall.
        hz.ex_rf_le = 1'b1; hz.ex_load = 1'b1; hz.mem_rf_le = 1'b1; hz.id_use_b = 1'b0;
        hz.id_ra = 5'd3;
        expect_now("fwd_load_skip", ALL, 1'b0, 1'b0, 2'd2, 2'd2, 2'd0, 16'h0001);
        tick();

        clear_in();
        hz.id_rd = 5'd0; hz.id_use_d = 1'b1; hz.ex_dest = 5'd0; hz.ex_rf_le = 1'b1;
        expect_now("r0_alu", ALL, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0001);
        tick();
        hz.ex_load = 1'b1;
        expect_now("r0_load", ALL, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0001);
        tick();

        clear_in();
        hz.ex_br_taken = 1'b1;
        expect_now("br_keep", ALL, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 16'h0001);
        tick();
        hz.ex_br_nullify = 1'b1;
        expect_now("br_null", ALL, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 16'h0001);
        tick();
        hz.ex_br_nullify = 1'b0;
        set_load_use();
        expect_now("br_over_lu", ALL, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 16'h0001);
        tick();
        hz.ex_br_taken = 1'b0;
        expect_now("lu_after_br", BUBL, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0001);
        tick();
        clear_in();
        expect_now("lu_after_br2", ALL, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0002);
        tick();

        reset = 1'b0;
        expect_now("reset2", NONE, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 16'h0002);
        tick();
        reset = 1'b1;
        set_load_use();
        hz.mem_wait = 1'b1;
        for (int i = 0; i < 4; i++) begin
            expect_now("mwait_freeze", NONE, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'(i));
            tick();
        end
        hz.mem_wait = 1'b0;
        expect_now("mwait_exit_lu", BUBL, 1'b1, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0004);
        tick();
        expect_now("mwait_lu_state", ALL, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0005);
        tick();

        hz.mem_wait = 1'b1;
        expect_now("mwait_again", NONE, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0005);
        tick();
        reset = 1'b0;
        expect_now("reset_in_mwait", NONE, 1'b1, 1'b1, 2'd0, 2'd0, 2'd0, 16'h0006);
        tick();
        reset = 1'b1;
        clear_in();
        expect_now("run_after_rst", ALL, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'h0000);
        tick();

        hz.mem_wait = 1'b1;
        for (int i = 0; i < 65535; i++) tick();
        expect_now("sat_reach", NONE, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'hFFFF);
        tick();
        expect_now("sat_hold", NONE, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'hFFFF);
        tick();
        hz.mem_wait = 1'b0;
        expect_now("sat_run", ALL, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 16'hFFFF);
        tick();

        for (int i = 0; i < 20 && q.size() > 0; i++) tick();
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending entries, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL use the following ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-low reset; 0 = reset.
- id_ra, id_rb, id_rd  in  5 each  source register numbers of the instruction in ID.
- id_use_a, id_use_b, id_use_d  in  1 each  the corresponding ID source is actually read.
- ex_dest  in  5  destination register of the instruction in EX.
- ex_rf_le  in  1  the EX instruction writes the register file.
- ex_load  in  1  the EX instruction is a load (L).
- mem_dest  in  5  destination register in MEM.
- mem_rf_le  in  1  the MEM instruction writes the register file.
- wb_dest  in  5  destination register in WB.
- wb_rf_le  in  1  the WB instruction writes the register file.
- ex_br_taken  in  1  the branch in EX resolved taken.
- ex_br_nullify  in  1  the taken branch nullifies its delay slot.
- mem_wait  in  1  data memory not ready; the whole pipeline must freeze.
- pc_le, npc_le, if_id_le  out  1 each  front-end load enables.
- id_ex_le, ex_mem_le, mem_wb_le  out  1 each  pipeline register load enables.
- cmux_sel  out  1  1 = inject all-zero (NOP) control into ID_EX.
- if_id_clr  out  1  1 = IF_ID loads a NOP instead of the fetched word.
- fwd_a, fwd_b, fwd_d  out  2 each  operand source select: 0 = RF, 1 = EX, 2 = MEM, 3 = WB.
- stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-002 SHALL implement an FSM with states RUN, LU, MWAIT.
REQ-003 Priority, highest first: reset, mem_wait, taken branch, load-use, normal.
REQ-004 Any state with mem_wait=1: all six LE outputs SHALL be 0, cmux_sel=0, if_id_clr=0; next state MWAIT.
REQ-005 MWAIT with mem_wait=0 SHALL evaluate the branch and load-use rules on the held inputs in that same cycle; next state RUN, or LU if load-use fires.
REQ-006 Load-use hazard definition:
- ex_load=1, ex_rf_le=1 and ex_dest!=0;
- ex_dest equals any ID source whose id_use_* is 1.
REQ-007 Load-use in RUN SHALL drive pc_le=npc_le=if_id_le=0, cmux_sel=1, and id_ex_le=ex_mem_le=mem_wb_le=1; next state LU. Latency is exactly one bubble.
REQ-008 LU SHALL suppress load-use detection, drive all LEs 1 and cmux_sel=0, and return to RUN.
REQ-009 ex_br_taken=1 in RUN or LU SHALL drive if_id_clr=1 with all LEs 1.
REQ-010 If ex_br_nullify=1 with a taken branch, cmux_sel SHALL also be 1 so the delay slot becomes a bubble. If the branch is not nullifying, the delay slot proceeds.
REQ-011 When branch and load-use conditions are both asserted, the branch SHALL win and no stall SHALL be taken.
REQ-012 Forwarding, per operand X in {a, b, d}:
- 1 if ex_rf_le & !ex_load & ex_dest==id_rX & id_rX!=0;
- else 2 if mem_rf_le & mem_dest==id_rX & id_rX!=0;
- else 3 if wb_rf_le & wb_dest==id_rX & id_rX!=0;
- else 0.
Forwarding is combinational, zero latency, and independent of FSM state.
REQ-013 stall_cnt SHALL increment by 1 for every cycle with pc_le=0 while reset=1, and SHALL saturate at 16'hFFFF.
REQ-014 Normal RUN SHALL drive all LEs 1, cmux_sel=0 and if_id_clr=0.

Reset
REQ-015 While reset=0 at a clock edge, the FSM SHALL go to RUN and stall_cnt SHALL go to 0, regardless of state, including mid-MWAIT or mid-LU.
REQ-016 While reset=0, outputs SHALL be:
- all LEs 0;
- cmux_sel=1, if_id_clr=1;
- fwd_a=fwd_b=fwd_d=0.
REQ-017 The first cycle after reset deasserts SHALL behave as RUN.

Structure
REQ-018 A shared package hazard_pkg SHALL hold:
- the FSM state enum;
- the FWD_RF, FWD_EX, FWD_MEM, FWD_WB encodings;
- the constant REG_ZERO=5'd0.
REQ-019 Operand selection SHALL be a sub-module fwd_select, instantiated three times (a, b, d). FSM and counter logic SHALL stay in the top module.

Verification
REQ-020 The bench SHALL cover these scenarios:
- Load r5 in EX, ID reads id_ra=5 with use_a=1: one cycle pc_le=0 and cmux_sel=1, then LU, then RUN; stall_cnt=1.
- ex_dest=3 (non-load, rf_le=1), mem_dest=3, wb_dest=3, id_rb=3: fwd_b=1; clear ex_rf_le: fwd_b=2; also clear mem_rf_le: fwd_b=3.
- id_rd=0 with ex_dest=0 and ex_rf_le=1: fwd_d=0 and no stall, even with ex_load=1.
- ex_br_taken=1, ex_br_nullify=0: if_id_clr=1, cmux_sel=0. With nullify=1: both 1, all LEs 1.
- mem_wait held 4 cycles during a load-use condition: all LEs 0 for 4 cycles, then one load-use bubble; stall_cnt=5.
- Reset asserted in MWAIT: next state RUN, stall_cnt=0. Preload stall_cnt at 16'hFFFF and stall: it stays at 16'hFFFF.
